divider_processor: RTL and testbench

//  Sequential unsigned 8-bit shift-subtract (restoring) divider; the inverse datapath of the lab's

---
 rtl/divider_processor_if.sv | 26 ++
 rtl/divider_processor.sv | 126 ++++++++++++
 tb/tb_divider_processor.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/divider_processor_if.sv
// Board-facing bundle for the divider: switch/button inputs and the register, hex and status outputs.
interface divider_processor_if #(parameter int WIDTH = 8);
  logic             run;
  logic             cleara_loadb;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] aval;
  logic [WIDTH-1:0] bval;
  logic [WIDTH-1:0] dval;
  logic [6:0]       AhexU;
  logic [6:0]       AhexL;
  logic [6:0]       BhexU;
  logic [6:0]       BhexL;
  logic             busy;
  logic             done;
  logic             dz;

  modport master (
    output run, cleara_loadb, s,
    input  aval, bval, dval, AhexU, AhexL, BhexU, BhexL, busy, done, dz
  );

  modport slave (
    input  run, cleara_loadb, s,
    output aval, bval, dval, AhexU, AhexL, BhexU, BhexL, busy, done, dz
  );
endinterface

// File: rtl/divider_processor.sv
// Sequential unsigned restoring divider: quotient in B, remainder in A, divisor in D.
// One SHIFT/TEST pair per quotient bit; a new division needs run to drop and rise again.
module divider_processor #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  divider_processor_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, TEST, HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   a9;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;
  logic             dz;
  logic             busy_c;
  logic             done_c;
  logic [WIDTH+1:0] diff;

  // Extra headroom bit so a shifted A that exceeds WIDTH bits still compares correctly.
  assign diff = {1'b0, a9} - {2'b00, d};

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      IDLE: if (bus.run) state_d = LOAD;
      LOAD: begin
        busy_c  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        busy_c  = 1'b1;
        state_d = TEST;
      end
      TEST: begin
        busy_c  = 1'b1;
        state_d = (cnt == CW'(WIDTH - 1)) ? HOLD : SHIFT;
      end
      HOLD: begin
        done_c = 1'b1;
        if (!bus.run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a9  <= '0;
      b   <= '0;
      d   <= '0;
      cnt <= '0;
      dz  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (!bus.run && bus.cleara_loadb) begin
          a9 <= '0;
          d  <= bus.s;
          dz <= 1'b0;
        end
        LOAD: begin
          b   <= bus.s;
          a9  <= '0;
          cnt <= '0;
          dz  <= (d == '0);
        end
        SHIFT: begin
          a9 <= {a9[WIDTH-1:0], b[WIDTH-1]};
          b  <= {b[WIDTH-2:0], 1'b0};
        end
        TEST: begin
          if (!diff[WIDTH+1]) begin
            a9   <= diff[WIDTH:0];
            b[0] <= 1'b1;
          end
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Active-low seven-segment patterns, segment g in bit 6.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign bus.aval  = a9[WIDTH-1:0];
  assign bus.bval  = b;
  assign bus.dval  = d;
  assign bus.AhexU = hex7(a9[7:4]);
  assign bus.AhexL = hex7(a9[3:0]);
  assign bus.BhexU = hex7(b[7:4]);
  assign bus.BhexL = hex7(b[3:0]);
  assign bus.busy  = busy_c;
  assign bus.done  = done_c;
  assign bus.dz    = dz;
endmodule

// File: tb/tb_divider_processor.sv
// Directed-vector bench for divider_processor with hand-computed quotients and remainders.
module tb_divider_processor;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  divider_processor_if #(.WIDTH(8)) bus ();

  divider_processor #(.WIDTH(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_d(input logic [7:0] v);
    bus.s = v;
    bus.cleara_loadb = 1'b1;
    tick();
    bus.cleara_loadb = 1'b0;
  endtask

  // Raises run and counts edges (including the sampling edge) until done is seen.
  task automatic run_div(input logic [7:0] v, output int edges, output bit timed_out);
    bus.s = v;
    bus.run = 1'b1;
    edges = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      edges++;
      if (bus.done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic release_run();
    bus.run = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.run = 1'b0;
    bus.cleara_loadb = 1'b0;
    bus.s = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    checks++;
    if (bus.aval !== 8'h00 || bus.bval !== 8'h00 || bus.dval !== 8'h00) begin
      errors++;
      $display("FAIL reset_regs: a=%h b=%h d=%h required 00/00/00", bus.aval, bus.bval, bus.dval);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dz !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b dz=%b required 0/0/0", bus.busy, bus.done, bus.dz);
    end
  endtask

  task automatic test_basic();
    int edges;
    bit to;
    load_d(8'h07);
    checks++;
    if (bus.dval !== 8'h07 || bus.aval !== 8'h00) begin
      errors++;
      $display("FAIL basic_load: d=%h a=%h required 07/00", bus.dval, bus.aval);
    end
    run_div(8'hC8, edges, to);
    checks++;
    if (to || edges !== 18) begin
      errors++;
      $display("FAIL basic_latency: edges=%0d timeout=%0b required 18/0", edges, to);
    end
    checks++;
    if (bus.bval !== 8'h1C || bus.aval !== 8'h04 || bus.dz !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: q=%h r=%h dz=%b busy=%b required 1c/04/0/0",
               bus.bval, bus.aval, bus.dz, bus.busy);
    end
    release_run();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: done=%b busy=%b required 0/0", bus.done, bus.busy);
    end
  endtask

  task automatic test_extremes();
    int edges;
    bit to;
    load_d(8'h01);
    run_div(8'hFF, edges, to);
    checks++;
    if (to || bus.bval !== 8'hFF || bus.aval !== 8'h00) begin
      errors++;
      $display("FAIL ff_div_1: q=%h r=%h timeout=%0b required ff/00/0", bus.bval, bus.aval, to);
    end
    release_run();
    load_d(8'hFF);
    run_div(8'hFF, edges, to);
    checks++;
    if (to || bus.bval !== 8'h01 || bus.aval !== 8'h00) begin
      errors++;
      $display("FAIL ff_div_ff: q=%h r=%h timeout=%0b required 01/00/0", bus.bval, bus.aval, to);
    end
    release_run();
  endtask

  task automatic test_small_dividend();
    int edges;
    bit to;
    load_d(8'h09);
    run_div(8'h05, edges, to);
    checks++;
    if (to || bus.bval !== 8'h00 || bus.aval !== 8'h05) begin
      errors++;
      $display("FAIL small_div: q=%h r=%h timeout=%0b required 00/05/0", bus.bval, bus.aval, to);
    end
    checks++;
    if (bus.BhexU !== 7'b1000000 || bus.BhexL !== 7'b1000000 ||
        bus.AhexU !== 7'b1000000 || bus.AhexL !== 7'b0010010) begin
      errors++;
      $display("FAIL small_hex: BU=%b BL=%b AU=%b AL=%b required 1000000/1000000/1000000/0010010",
               bus.BhexU, bus.BhexL, bus.AhexU, bus.AhexL);
    end
    release_run();
  endtask

  task automatic test_div_zero();
    int edges;
    bit to;
    load_d(8'h00);
    run_div(8'h64, edges, to);
    checks++;
    if (to || bus.bval !== 8'hFF || bus.aval !== 8'h64 || bus.dz !== 1'b1) begin
      errors++;
      $display("FAIL dz_result: q=%h r=%h dz=%b timeout=%0b required ff/64/1/0",
               bus.bval, bus.aval, bus.dz, to);
    end
    release_run();
    checks++;
    if (bus.dz !== 1'b1) begin
      errors++;
      $display("FAIL dz_sticky: dz=%b required 1", bus.dz);
    end
    load_d(8'h03);
    checks++;
    if (bus.dz !== 1'b0 || bus.dval !== 8'h03 || bus.aval !== 8'h00) begin
      errors++;
      $display("FAIL dz_clear: dz=%b d=%h a=%h required 0/03/00", bus.dz, bus.dval, bus.aval);
    end
  endtask

  task automatic test_hold_run();
    int edges;
    bit to;
    int bad = 0;
    load_d(8'h0C);
    run_div(8'h64, edges, to);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.bval !== 8'h08 || bus.aval !== 8'h04) bad++;
    end
    checks++;
    if (to || bad !== 0) begin
      errors++;
      $display("FAIL hold_run: bad_cycles=%0d timeout=%0b required 0/0", bad, to);
    end
    release_run();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_drop: done=%b busy=%b required 0/0", bus.done, bus.busy);
    end
    run_div(8'h64, edges, to);
    checks++;
    if (to || edges !== 18 || bus.bval !== 8'h08 || bus.aval !== 8'h04) begin
      errors++;
      $display("FAIL hold_rerun: edges=%0d q=%h r=%h required 18/08/04", edges, bus.bval, bus.aval);
    end
    release_run();
  endtask

  task automatic test_ignore_clear();
    int edges;
    bit to;
    load_d(8'h0A);
    bus.s = 8'h64;
    bus.run = 1'b1;
    repeat (3) tick();
    bus.cleara_loadb = 1'b1;
    bus.s = 8'h33;
    to = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (bus.done === 1'b1) begin
        to = 1'b0;
        break;
      end
      tick();
    end
    checks++;
    if (to || bus.dval !== 8'h0A || bus.bval !== 8'h0A || bus.aval !== 8'h00) begin
      errors++;
      $display("FAIL clear_ignored: d=%h q=%h r=%h timeout=%0b required 0a/0a/00/0",
               bus.dval, bus.bval, bus.aval, to);
    end
    bus.cleara_loadb = 1'b0;
    release_run();
  endtask

  task automatic test_mid_reset();
    load_d(8'h05);
    bus.s = 8'h64;
    bus.run = 1'b1;
    repeat (9) tick();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: busy=%b required 1", bus.busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.run = 1'b0;
    checks++;
    if (bus.aval !== 8'h00 || bus.bval !== 8'h00 || bus.dval !== 8'h00 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: a=%h b=%h d=%h busy=%b done=%b required 00/00/00/0/0",
               bus.aval, bus.bval, bus.dval, bus.busy, bus.done);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_small_dividend();
    test_div_zero();
    test_hold_run();
    test_ignore_clear();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
